// File: rtl/vector_pkg.sv
// Shared types for the vector ALU sequencer: opcode and sequencer state enums.
package vector_pkg;

  // ALU opcodes carried on op_o
  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2
  } vop_e;

  // Sequencer control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } vseq_state_e;

endpackage

// File: rtl/vseq_delay.sv
// Fixed-depth shift register carrying {writeback valid, writeback address}
// from the ALU operand stage to the writeback stage.
module vseq_delay #(
  parameter int depth_p = 1,
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] d_i,
  output logic [width_p-1:0] q_o
);

  logic [width_p-1:0] r_stage [depth_p];

  // Shift one stage per cycle; reset empties every stage
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < depth_p; i++) begin
        r_stage[i] <= {width_p{1'b0}};
      end
    end else begin
      r_stage[0] <= d_i;
      for (int i = 1; i < depth_p; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign q_o = r_stage[depth_p-1];

endmodule

// File: rtl/vector_alu_sequencer.sv
// Vector ALU sequencer: walks a vector command element by element, issuing
// register-file reads, presenting ALU operands and tracking writebacks.
// Optional feature macro: VECTOR_ALU_SEQUENCER_SCALAR_EN (scalar b operand).
module vector_alu_sequencer
  import vector_pkg::*;
#(
  parameter int vdw_p     = 32,
  parameter int op_len_p  = 2,
  parameter int els_p     = 16,
  parameter int nregs_p   = 8,
  parameter int alu_lat_p = 1,
  localparam int idx_w    = $clog2(els_p),
  localparam int reg_w    = $clog2(nregs_p),
  localparam int addr_w   = reg_w + idx_w,
  localparam int len_w    = $clog2(els_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    cmd_v_i,
  output logic                    cmd_ready_o,
  input  logic [op_len_p-1:0]     cmd_op_i,
  input  logic [reg_w-1:0]        cmd_vs1_i,
  input  logic [reg_w-1:0]        cmd_vs2_i,
  input  logic [reg_w-1:0]        cmd_vd_i,
  input  logic [len_w-1:0]        cmd_len_i,
`ifdef VECTOR_ALU_SEQUENCER_SCALAR_EN
  input  logic                    cmd_scalar_v_i,
  input  logic [vdw_p-1:0]        cmd_scalar_i,
`endif
  output logic                    rd_en_o,
  output logic [addr_w-1:0]       rd_addr_a_o,
  output logic [addr_w-1:0]       rd_addr_b_o,
  input  logic [vdw_p-1:0]        rd_data_a_i,
  input  logic [vdw_p-1:0]        rd_data_b_i,
  output logic signed [vdw_p-1:0] a_o,
  output logic signed [vdw_p-1:0] b_o,
  output logic [op_len_p-1:0]     op_o,
  output logic                    alu_v_o,
  output logic                    wb_v_o,
  output logic [addr_w-1:0]       wb_addr_o,
  output logic                    done_o
);

  vseq_state_e         r_state;
  vseq_state_e         w_next_state;
  logic [idx_w-1:0]    r_idx;
  logic [op_len_p-1:0] r_op;
  logic [reg_w-1:0]    r_vs1;
  logic [reg_w-1:0]    r_vs2;
  logic [reg_w-1:0]    r_vd;
  logic [len_w-1:0]    r_len;
  logic                r_alu_v;
  logic [idx_w-1:0]    r_alu_idx;
  logic                r_zero_done;

  logic                w_accept;
  logic [len_w-1:0]    w_len;
  logic                w_rd_en;
  logic                w_last_issue;
  logic [addr_w:0]     w_dly_d;
  logic [addr_w:0]     w_dly_q;
  logic                w_wb_v;
  logic [addr_w-1:0]   w_wb_addr;
  logic                w_last_wb;
  logic [vdw_p-1:0]    w_b_src;
  logic                w_b_from_rf;

  assign w_accept     = cmd_v_i & (r_state == ST_IDLE);
  // Over-long requests are clamped to the register length
  assign w_len        = (cmd_len_i > len_w'(els_p)) ? len_w'(els_p) : cmd_len_i;
  assign w_rd_en      = (r_state == ST_RUN);
  assign w_last_issue = (len_w'(r_idx) == (r_len - len_w'(1)));

`ifdef VECTOR_ALU_SEQUENCER_SCALAR_EN
  logic             r_scalar_v;
  logic [vdw_p-1:0] r_scalar;

  // Latch the scalar operand with the command
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_scalar_v <= 1'b0;
      r_scalar   <= {vdw_p{1'b0}};
    end else if (w_accept) begin
      r_scalar_v <= cmd_scalar_v_i;
      r_scalar   <= cmd_scalar_i;
    end
  end

  assign w_b_from_rf = ~r_scalar_v;
  assign w_b_src     = r_scalar_v ? r_scalar : rd_data_b_i;
`else
  assign w_b_from_rf = 1'b1;
  assign w_b_src     = rd_data_b_i;
`endif

  // Writeback pipeline: only valid slots carry an address
  assign w_dly_d   = {r_alu_v, (r_alu_v ? {r_vd, r_alu_idx} : {addr_w{1'b0}})};
  assign w_wb_v    = w_dly_q[addr_w];
  assign w_wb_addr = w_dly_q[addr_w-1:0];
  // The element with index len-1 is always the final writeback
  assign w_last_wb = (r_state == ST_DRAIN) & w_wb_v &
                     (len_w'(w_wb_addr[idx_w-1:0]) == (r_len - len_w'(1)));

  vseq_delay #(
    .depth_p (alu_lat_p),
    .width_p (addr_w + 1)
  ) u_delay (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (w_dly_d),
    .q_o     (w_dly_q)
  );

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (w_len != len_w'(0))) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_last_issue) begin
          w_next_state = ST_DRAIN;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (w_last_wb) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_DRAIN;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Command latch, element index and operand-stage tracking
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_idx       <= {idx_w{1'b0}};
      r_op        <= {op_len_p{1'b0}};
      r_vs1       <= {reg_w{1'b0}};
      r_vs2       <= {reg_w{1'b0}};
      r_vd        <= {reg_w{1'b0}};
      r_len       <= {len_w{1'b0}};
      r_alu_v     <= 1'b0;
      r_alu_idx   <= {idx_w{1'b0}};
      r_zero_done <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= cmd_op_i;
        r_vs1 <= cmd_vs1_i;
        r_vs2 <= cmd_vs2_i;
        r_vd  <= cmd_vd_i;
        r_len <= w_len;
        r_idx <= {idx_w{1'b0}};
      end else if (w_rd_en) begin
        r_idx <= w_last_issue ? {idx_w{1'b0}} : (r_idx + idx_w'(1));
      end
      r_zero_done <= w_accept & (w_len == len_w'(0));
      r_alu_v     <= w_rd_en;
      r_alu_idx   <= r_idx;
    end
  end

  assign cmd_ready_o = (r_state == ST_IDLE);
  assign rd_en_o     = w_rd_en;
  assign rd_addr_a_o = w_rd_en ? {r_vs1, r_idx} : {addr_w{1'b0}};
  assign rd_addr_b_o = (w_rd_en & w_b_from_rf) ? {r_vs2, r_idx} : {addr_w{1'b0}};
  assign alu_v_o     = r_alu_v;
  assign a_o         = r_alu_v ? rd_data_a_i : {vdw_p{1'b0}};
  assign b_o         = r_alu_v ? w_b_src : {vdw_p{1'b0}};
  assign op_o        = r_alu_v ? r_op : {op_len_p{1'b0}};
  assign wb_v_o      = w_wb_v;
  assign wb_addr_o   = w_wb_addr;
  assign done_o      = r_zero_done | w_last_wb;

endmodule
